stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with per-channel valid/ready handshakes and a registered output stage. It selects either a host-driven fixed channel or a fair round-robin choice among requesting channels. It is the sequential, back-pressure-aware successor of the combinational 8:1 bit mux. It sits between multiple producer streams and a single consumer.

## Interface
- NUM_CH, default 8: number of input channels, 2..64, not required to be a power of two.
- DATA_W, default 8: data width per channel, ≥1.
- SEL_W, default $clog2(NUM_CH): select/channel-index width, derived, not overridden.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used when mode = 0.
- in_valid  in  NUM_CH  per-channel data valid.
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel accept; at most one bit high per cycle.
- out_valid  out  1  output register holds a word.
- out_data  out  DATA_W  registered selected data.
- out_ch  out  SEL_W  index of the channel out_data came from.
- out_ready  in  1  consumer accept.

## Operation
- Transfers:
  - An input transfer on channel i occurs when in_valid[i] && in_ready[i].
  - An output transfer occurs when out_valid && out_ready.
- load_en = !out_valid || out_ready. The output register accepts a new word only when load_en is high.
- Grant, evaluated combinationally each cycle:
  - mode = 0:
    - grant = sel if sel < NUM_CH and in_valid[sel].
    - Otherwise there is no grant.
    - An out-of-range sel never grants.
  - mode = 1:
    - grant = the first index with in_valid set, searching ptr, ptr+1, …, NUM_CH-1, 0, …, ptr-1.
    - No grant if no bit is set.
- in_ready[g] = load_en && grant_valid, for g = grant only. All other bits are 0.
- On an input transfer:
  - out_data ← in_data[g].
  - out_ch ← g.
  - out_valid ← 1.
- If load_en is high with no grant, out_valid ← 0. out_data and out_ch hold their last values.
- If load_en is low, the output register holds every field (stall).
- Round-robin pointer ptr:
  - Updates only on an input transfer that occurs in mode 1: ptr ← (g+1 == NUM_CH) ? 0 : g+1.
  - Mode-0 transfers leave ptr unchanged.
  - Switching mode takes effect on the same cycle's grant; ptr is retained across mode changes.
- Input data is not required to be stable while in_ready is low. Nothing is captured without a transfer.

## Timing
- Reset values (asynchronous assertion): out_valid = 0, out_data = 0, out_ch = 0, ptr = 0. in_ready = 0 while rst is high.
- Latency: 1 cycle from input transfer to out_valid / out_data.
- Throughput: 1 word per cycle with out_ready held high.
- Stall: out_valid && !out_ready holds out_data and out_ch stable, and forces all in_ready low.
- Simultaneous output and input transfers in one cycle are legal. The register reloads with no bubble.
- in_ready depends combinationally on in_valid, mode, sel and out_ready. There is no combinational path from any input to out_valid, out_data or out_ch.
- Reset asserted mid-stall: the held word is discarded and the register returns to reset values.
- ptr wraps from NUM_CH-1 to 0, including when NUM_CH is not a power of two.

## Structure
- Shared package stream_mux_pkg:
  - mode encoding constants MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - function next_idx(idx, n) implementing the wrap increment.
- Sub-module rr_pick:
  - Combinational rotating priority picker.
  - Inputs: request vector and ptr.
  - Outputs: grant_valid and grant index.
  - Implemented as a double-width masked priority encode.
- Top level holds ptr, the load_en logic and the output register.

## Test plan
- Reset mid-stall:
  - Setup: NUM_CH = 8, DATA_W = 8, rst pulsed while out_valid = 1 and out_ready = 0.
  - Required: out_valid, out_data and out_ch go to 0 immediately (asynchronous). After release, the first mode-1 grant goes to the lowest valid index.
- Fixed mode:
  - Setup: mode = 0, sel = 5, in_valid = 8'hFF, in_data[5] = 8'hA5, out_ready = 1.
  - Required: in_ready = 8'h20. Next cycle out_data = 8'hA5 and out_ch = 5, every cycle.
- Round-robin fairness:
  - Setup: mode = 1, in_valid = 8'b1000_0101 held, out_ready = 1.
  - Required: grant sequence 0, 2, 7, 0, 2, 7 on consecutive cycles.
- Back-pressure:
  - Setup: mode = 1, out_ready = 0 for 3 cycles after the first load.
  - Required: out_data held, in_ready = 0 during the stall, ptr unchanged. On release, the next channel is granted in the same cycle the held word drains.
- Out-of-range select:
  - Setup: NUM_CH = 5, mode = 0, sel = 6, all in_valid high.
  - Required: in_ready = 0. out_valid falls to 0 after the held word drains.
- Mode switch:
  - Setup: mode 1 grants channel 3 (ptr = 4), then mode 0 with sel = 1 for 2 transfers, then back to mode 1 with all valid.
  - Required: next grant is 4.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Wrap increment that works for any channel count, not only powers of two.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping past N-1.
module rr_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          grant_vld_o,
  output logic [IW-1:0] grant_o
);

  logic [2*N-1:0] dbl;

  // Upper copy keeps all requests so the search wraps; lower copy hides those below ptr.
  always_comb begin
    dbl = {req_i, req_i};
    for (int i = 0; i < N; i++) begin
      if (i < int'(ptr_i)) dbl[i] = 1'b0;
    end
    grant_vld_o = 1'b0;
    grant_o     = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) begin
        grant_vld_o = 1'b1;
        grant_o     = (i >= N) ? IW'(i - N) : IW'(i);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream mux with fixed or round-robin selection and a registered output stage.
// One-cycle latency; a held output word blocks all inputs until the consumer accepts it.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_dat_q, out_dat_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic              load_en;
  logic              rr_vld;
  logic [SEL_W-1:0]  rr_idx;
  logic              fix_vld;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant;
  logic [DATA_W-1:0] grant_dat;
  logic              xfer;

  rr_pick #(.N(NUM_CH), .IW(SEL_W)) u_pick (
    .req_i       (in_valid),
    .ptr_i       (ptr_q),
    .grant_vld_o (rr_vld),
    .grant_o     (rr_idx)
  );

  assign load_en = !out_vld_q || out_ready;

  // Comparing against each legal index means an out-of-range sel never matches.
  always_comb begin
    fix_vld = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (SEL_W'(i) == sel) fix_vld = in_valid[i];
    end
  end

  assign grant_vld = (mode == MODE_RR) ? rr_vld : fix_vld;
  assign grant     = (mode == MODE_RR) ? rr_idx : sel;
  assign xfer      = load_en && grant_vld && !rst;

  always_comb begin
    in_ready  = '0;
    grant_dat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (SEL_W'(i) == grant) begin
        in_ready[i] = xfer;
        grant_dat   = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_ch_d  = out_ch_q;
    ptr_d     = ptr_q;
    if (load_en) begin
      out_vld_d = grant_vld;
      if (grant_vld) begin
        out_dat_d = grant_dat;
        out_ch_d  = grant;
        if (mode == MODE_RR) ptr_d = SEL_W'(next_idx(32'(grant), NUM_CH));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_ch_q  <= '0;
      ptr_q     <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_ch_q  <= out_ch_d;
      ptr_q     <= ptr_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: an 8-channel and a 5-channel instance.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m8, ordy8, ov8;
  logic [2:0]  sel8, och8;
  logic [7:0]  v8, rdy8, od8;
  logic [63:0] d8;

  logic        m5, ordy5, ov5;
  logic [2:0]  sel5, och5;
  logic [4:0]  v5, rdy5;
  logic [7:0]  od5;
  logic [39:0] d5;

  int n_tests = 0;
  int n_fail  = 0;

  stream_mux_rr #(.NUM_CH(8), .DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .mode(m8), .sel(sel8), .in_valid(v8), .in_data(d8),
    .in_ready(rdy8), .out_valid(ov8), .out_data(od8), .out_ch(och8), .out_ready(ordy8)
  );

  stream_mux_rr #(.NUM_CH(5), .DATA_W(8)) dut5 (
    .clk(clk), .rst(rst), .mode(m5), .sel(sel5), .in_valid(v5), .in_data(d5),
    .in_ready(rdy5), .out_valid(ov5), .out_data(od5), .out_ch(och5), .out_ready(ordy5)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rr_seq [6] = '{0, 2, 7, 0, 2, 7};
  int rr5_seq[6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    for (int i = 0; i < 8; i++) d8[i*8 +: 8] = 8'hA0 + 8'(i);
    for (int i = 0; i < 5; i++) d5[i*8 +: 8] = 8'h50 + 8'(i);
    m8 = 1'b1; sel8 = 3'd0; v8 = 8'hFF; ordy8 = 1'b1;
    m5 = 1'b0; sel5 = 3'd0; v5 = 5'h00; ordy5 = 1'b1;

    // Reset state, with requests present
    #2;
    check("rst_in_ready", 64'(rdy8), 64'h0);
    check("rst_out_valid", 64'(ov8), 64'h0);
    check("rst_out_data", 64'(od8), 64'h0);
    check("rst_out_ch", 64'(och8), 64'h0);
    tick();
    tick();
    rst = 1'b0;

    // Fixed select on channel 5
    m8 = 1'b0; sel8 = 3'd5; v8 = 8'hFF; ordy8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check("fix_in_ready", 64'(rdy8), 64'h20);
      tick();
      check("fix_out_valid", 64'(ov8), 64'h1);
      check("fix_out_data", 64'(od8), 64'hA5);
      check("fix_out_ch", 64'(och8), 64'd5);
    end

    // Round-robin fairness; ptr is still 0 after the fixed-mode transfers
    m8 = 1'b1; v8 = 8'b1000_0101;
    for (int k = 0; k < 6; k++) begin
      #1 check("rr_in_ready", 64'(rdy8), 64'(8'h01 << rr_seq[k]));
      tick();
      check("rr_out_ch", 64'(och8), 64'(rr_seq[k]));
      check("rr_out_data", 64'(od8), 64'(8'hA0 + 8'(rr_seq[k])));
    end

    // Back-pressure: load channel 0, stall 3 cycles, then drain and reload
    v8 = 8'hFF;
    #1 check("bp_first_ready", 64'(rdy8), 64'h01);
    tick();
    ordy8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_stall_ready", 64'(rdy8), 64'h0);
      tick();
      check("bp_hold_valid", 64'(ov8), 64'h1);
      check("bp_hold_data", 64'(od8), 64'hA0);
      check("bp_hold_ch", 64'(och8), 64'd0);
    end
    ordy8 = 1'b1;
    #1 check("bp_release_ready", 64'(rdy8), 64'h02);
    tick();
    check("bp_release_ch", 64'(och8), 64'd1);
    check("bp_release_data", 64'(od8), 64'hA1);

    // Reset mid-stall; ptr was 2, so a surviving ptr would pick channel 2
    ordy8 = 1'b0;
    tick();
    check("stall_before_rst", 64'(ov8), 64'h1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(ov8), 64'h0);
    check("async_rst_data", 64'(od8), 64'h0);
    check("async_rst_ch", 64'(och8), 64'h0);
    tick();
    rst = 1'b0;
    v8 = 8'h06; ordy8 = 1'b1;
    #1 check("post_rst_ready", 64'(rdy8), 64'h02);
    tick();
    check("post_rst_ch", 64'(och8), 64'd1);

    // Mode switch: grant 3 (ptr=4), two fixed transfers on sel 1, back to round-robin
    v8 = 8'h08;
    #1 check("ms_rr3_ready", 64'(rdy8), 64'h08);
    tick();
    check("ms_rr3_ch", 64'(och8), 64'd3);
    m8 = 1'b0; sel8 = 3'd1; v8 = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      #1 check("ms_fix_ready", 64'(rdy8), 64'h02);
      tick();
      check("ms_fix_ch", 64'(och8), 64'd1);
    end
    m8 = 1'b1;
    #1 check("ms_rr_ready", 64'(rdy8), 64'h10);
    tick();
    check("ms_rr_ch", 64'(och8), 64'd4);
    check("ms_rr_data", 64'(od8), 64'hA4);

    // Out-of-range select on the 5-channel instance
    m5 = 1'b0; sel5 = 3'd2; v5 = 5'h1F; ordy5 = 1'b1;
    tick();
    check("oor_load_valid", 64'(ov5), 64'h1);
    check("oor_load_data", 64'(od5), 64'h52);
    sel5 = 3'd6;
    #1 check("oor_ready", 64'(rdy5), 64'h0);
    tick();
    check("oor_drained_valid", 64'(ov5), 64'h0);
    check("oor_hold_ch", 64'(och5), 64'd2);
    check("oor_hold_data", 64'(od5), 64'h52);

    // Non-power-of-two pointer wrap
    m5 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 check("wrap5_ready", 64'(rdy5), 64'(5'h01 << rr5_seq[k]));
      tick();
      check("wrap5_ch", 64'(och5), 64'(rr5_seq[k]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
